// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequence controller and its helpers.
package lstm_pkg;

  // Default fixed-point format for samples and recurrent state.
  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  // Width of the settle down-counter; it bounds the cell latency to 1..15.
  localparam int SETTLE_W = 4;

  // Signed fixed-point sample in the default format.
  typedef logic signed [LSTM_DATA_WIDTH-1:0] sample_t;

  // Sequencing states: waiting for a sample, letting the cell settle,
  // presenting the captured result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    EMIT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/lstm_settle_timer.sv
// Loadable down-counter that flags when the cell inputs have settled long enough.
module lstm_settle_timer
  import lstm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                en,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  // Load takes priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Drives a combinational LSTM cell across the timesteps of a sequence,
// feeding back the captured c/h and clearing them at sequence end.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH   = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH  = LSTM_FRACT_WIDTH,
  parameter int CELL_LATENCY = 2,
  parameter int STEP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic [DATA_WIDTH-1:0] out_h,
  output logic                  out_last,
  output logic [STEP_W-1:0]     out_step
);

  // The settle count is loaded with one less than the latency because the
  // capture happens on the cycle the counter reads zero.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(CELL_LATENCY - 1);

  // Reject parameter sets the 4-bit settle counter or format cannot represent.
  if ((CELL_LATENCY < 1) || (CELL_LATENCY > 15) ||
      (FRACT_WIDTH < 0) || (FRACT_WIDTH >= DATA_WIDTH)) begin : g_param_check
    $error("lstm_seq_ctrl: CELL_LATENCY must be 1..15 and FRACT_WIDTH below DATA_WIDTH");
  end

  seq_state_t state;
  logic       last_q;
  logic       timer_load;
  logic       timer_en;
  logic       settle_zero;

  // Start the settle window on the input handshake and run it during EVAL.
  assign timer_load = (state == IDLE) && in_valid;
  assign timer_en   = (state == EVAL);

  lstm_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (timer_en),
    .zero     (settle_zero)
  );

  // Sequencer: accept a sample, hold the cell inputs while it settles,
  // capture and present the result, then fold it back as recurrent state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_c     <= '0;
      out_h     <= '0;
      out_step  <= '0;
      cell_x    <= '0;
      cell_c    <= '0;
      cell_h    <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cell_x   <= in_x;
            last_q   <= in_last;
            in_ready <= 1'b0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          if (settle_zero) begin
            out_c     <= cell_c_out;
            out_h     <= cell_h_out;
            out_last  <= last_q;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              cell_c   <= '0;
              cell_h   <= '0;
              out_step <= '0;
            end else begin
              cell_c   <= out_c;
              cell_h   <= out_h;
              out_step <= out_step + 1'b1;
            end
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl with a stub adder cell and a
// sequence-level reference model of the expected c/h/step values.
module tb_lstm_seq_ctrl;

  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int SW  = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic          in_last;
  logic [DW-1:0] cell_x;
  logic [DW-1:0] cell_c;
  logic [DW-1:0] cell_h;
  logic [DW-1:0] cell_c_out;
  logic [DW-1:0] cell_h_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_c;
  logic [DW-1:0] out_h;
  logic          out_last;
  logic [SW-1:0] out_step;

  int total = 0;
  int bad   = 0;

  // Reference model: recurrent state and step index of the current sequence.
  logic [DW-1:0] modelC;
  logic [DW-1:0] modelH;
  int            modelStep;

  // Values captured from the most recent emitted result.
  logic [DW-1:0] gotC;
  logic [DW-1:0] gotH;
  logic [SW-1:0] gotStep;
  logic          gotLast;

  lstm_seq_ctrl #(
    .DATA_WIDTH   (DW),
    .FRACT_WIDTH  (8),
    .CELL_LATENCY (LAT),
    .STEP_W       (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_last    (in_last),
    .cell_x     (cell_x),
    .cell_c     (cell_c),
    .cell_h     (cell_h),
    .cell_c_out (cell_c_out),
    .cell_h_out (cell_h_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_h      (out_h),
    .out_last   (out_last),
    .out_step   (out_step)
  );

  // Stub cell: c_out = x + c, h_out = x + h.
  assign cell_c_out = cell_x + cell_c;
  assign cell_h_out = cell_x + cell_h;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one sample and complete the input handshake.
  task automatic applyStimulus(input logic [DW-1:0] x, input logic last);
    int n;
    n = 0;
    in_x     = x;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    in_x     = DW'($urandom);
    in_last  = 1'($urandom);
  endtask

  // One full timestep: feed x, check latency and result against the model,
  // optionally stall the consumer for `hold` cycles, then complete the transfer.
  task automatic runSample(input logic [DW-1:0] x, input logic last, input int hold);
    logic [DW-1:0] expC;
    logic [DW-1:0] expH;
    int            n;
    expC = x + modelC;
    expH = x + modelH;
    out_ready = (hold == 0);
    applyStimulus(x, last);
    checkOutput("eval_cell_x", 32'(cell_x), 32'(x));
    checkOutput("eval_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    checkOutput("latency", n, LAT);
    checkOutput("out_c", 32'(out_c), 32'(expC));
    checkOutput("out_h", 32'(out_h), 32'(expH));
    checkOutput("out_last", 32'(out_last), 32'(last));
    checkOutput("out_step", 32'(out_step), 32'(modelStep % (1 << SW)));
    checkOutput("emit_in_ready", 32'(in_ready), 32'd0);
    gotC    = out_c;
    gotH    = out_h;
    gotStep = out_step;
    gotLast = out_last;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_x     = DW'($urandom);
      tick;
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_c", 32'(out_c), 32'(expC));
      checkOutput("hold_out_h", 32'(out_h), 32'(expH));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    checkOutput("post_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    if (last) begin
      modelC    = '0;
      modelH    = '0;
      modelStep = 0;
    end else begin
      modelC    = expC;
      modelH    = expH;
      modelStep = (modelStep + 1) % (1 << SW);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    modelC    = '0;
    modelH    = '0;
    modelStep = 0;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_c", 32'(out_c), 32'd0);
    checkOutput("rst_cell_c", 32'(cell_c), 32'd0);
    checkOutput("rst_out_step", 32'(out_step), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    $display("[TB] single-element sequence");
    runSample(16'h0100, 1'b1, 0);
    checkOutput("single_c", 32'(gotC), 32'h0100);
    checkOutput("single_h", 32'(gotH), 32'h0100);
    checkOutput("single_last", 32'(gotLast), 32'd1);
    checkOutput("single_step", 32'(gotStep), 32'd0);
    checkOutput("single_cell_c_clear", 32'(cell_c), 32'd0);
    checkOutput("single_cell_h_clear", 32'(cell_h), 32'd0);

    $display("[TB] three-element sequence");
    runSample(16'h0100, 1'b0, 0);
    checkOutput("seq3_c0", 32'(gotC), 32'h0100);
    checkOutput("seq3_last0", 32'(gotLast), 32'd0);
    runSample(16'h0200, 1'b0, 0);
    checkOutput("seq3_c1", 32'(gotC), 32'h0300);
    checkOutput("seq3_step1", 32'(gotStep), 32'd1);
    runSample(16'h0080, 1'b1, 0);
    checkOutput("seq3_c2", 32'(gotC), 32'h0380);
    checkOutput("seq3_h2", 32'(gotH), 32'h0380);
    checkOutput("seq3_step2", 32'(gotStep), 32'd2);
    checkOutput("seq3_last2", 32'(gotLast), 32'd1);

    $display("[TB] back-pressure");
    runSample(16'h0040, 1'b1, 10);
    tick;
    checkOutput("bp_single_transfer", 32'(out_valid), 32'd0);
    checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);

    $display("[TB] sequence boundary");
    for (int s = 0; s < 2; s++) begin
      runSample(16'h0100, 1'b0, 0);
      checkOutput("bound_c0", 32'(gotC), 32'h0100);
      runSample(16'h0100, 1'b1, 0);
      checkOutput("bound_c1", 32'(gotC), 32'h0200);
      checkOutput("bound_h1", 32'(gotH), 32'h0200);
    end

    $display("[TB] reset mid-EVAL");
    runSample(16'h0123, 1'b0, 0);
    applyStimulus(16'h0200, 1'b1);
    tick;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_out_c", 32'(out_c), 32'd0);
    checkOutput("mrst_out_h", 32'(out_h), 32'd0);
    checkOutput("mrst_out_last", 32'(out_last), 32'd0);
    checkOutput("mrst_out_step", 32'(out_step), 32'd0);
    checkOutput("mrst_cell_x", 32'(cell_x), 32'd0);
    checkOutput("mrst_cell_c", 32'(cell_c), 32'd0);
    checkOutput("mrst_cell_h", 32'(cell_h), 32'd0);
    modelC    = '0;
    modelH    = '0;
    modelStep = 0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    checkOutput("mrst_no_emit", 32'(out_valid), 32'd0);
    checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
    runSample(16'h0100, 1'b1, 0);
    checkOutput("mrst_after_c", 32'(gotC), 32'h0100);
    checkOutput("mrst_after_step", 32'(gotStep), 32'd0);

    $display("[TB] step wrap");
    for (int i = 0; i < 5; i++) begin
      runSample(16'h0001, 1'b0, 0);
      checkOutput("wrap_step", 32'(gotStep), 32'(i % 4));
    end
    runSample(16'h0001, 1'b1, 0);

    $display("[TB] random sequences");
    for (int i = 0; i < 24; i++) begin
      runSample(DW'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
